// File: rtl/rr_arbiter.sv
// rr_arbiter: registered N-way arbiter with fixed or round-robin priority.
//
// A grant, once issued, is held until the holder releases it (explicitly via
// grant_release or implicitly by dropping its request). On release the next
// winner is picked in the same cycle, so back-to-back grants have no idle
// bubble. All outputs come straight from flops; there is no combinational
// path from req to grant.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req           request vector, bit i = requester i
//   enable        permits new grants; never revokes a held grant
//   grant_release holder is done; only looked at while grant_valid=1
//                 ('release' itself is a reserved word in SystemVerilog)
//   grant         registered one-hot grant
//   grant_idx     registered index of the granted requester, 0 when idle
//   grant_valid   registered, 1 while a grant is held
module rr_arbiter #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3,
  parameter bit          RR    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             enable,
  input  logic             grant_release,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  localparam logic [0:0]       StIdle  = 1'b0;
  localparam logic [0:0]       StGrant = 1'b1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  logic [0:0]       state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [N-1:0]     cand_req;
  logic [IDX_W-1:0] cand_ptr;
  logic             try_grant;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // Priority runs downward from pointer t and wraps: t, t-1, ..., 0, N-1, ..., t+1.
  // Each requester's distance below t (mod N) is its rank; lowest rank wins.
  function automatic void pick(input logic [N-1:0] r, input logic [IDX_W-1:0] t,
                               output logic found, output logic [IDX_W-1:0] win);
    int best_d;
    int d;
    found  = 1'b0;
    win    = '0;
    best_d = int'(N);
    for (int j = 0; j < int'(N); j++) begin
      d = (int'(t) - j + int'(N)) % int'(N);
      if (r[j] && d < best_d) begin
        best_d = d;
        found  = 1'b1;
        win    = IDX_W'(j);
      end
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cand_req  = req;
    cand_ptr  = ptr_q;
    try_grant = 1'b0;
    win_found = 1'b0;
    win_idx   = '0;

    unique case (state_q)
      StIdle: begin
        try_grant = enable;
      end
      StGrant: begin
        // Holder's own request dropping counts as a release.
        if (grant_release || !(|(req & grant_q))) begin
          if (RR) begin
            ptr_d = (idx_q == '0) ? LastIdx : idx_q - 1'b1;
          end
          // Re-arbitrate this same edge with the updated pointer, holder masked.
          cand_req  = req & ~grant_q;
          cand_ptr  = ptr_d;
          try_grant = enable;
          state_d   = StIdle;
          grant_d   = '0;
          idx_d     = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    pick(cand_req, cand_ptr, win_found, win_idx);

    if (try_grant && win_found) begin
      state_d = StGrant;
      grant_d = {{(N - 1){1'b0}}, 1'b1} << win_idx;
      idx_d   = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= LastIdx;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = (state_q == StGrant);

endmodule
